// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the delta-sigma decimation path.
// Also used by dsm_cic_decimator (optional startup suppression: DSM_DEC_SETTLE_EN).
package dsm_pkg;

    localparam int                  SAMPLE_W  = 20;
    localparam logic [SAMPLE_W-1:0] VIN_FS    = 20'h0_8000;
    localparam int                  CIC_ORDER = 3;

    // DSM bit to bipolar level: 1 -> +1, 0 -> -1
    function automatic logic signed [1:0] bit_to_pm1(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

    function automatic int log2_decim(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// Enable-gated modulo-2^W accumulator; one instance per CIC integrator stage.
module cic_integrator #(
    parameter int W = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) acc_d = acc_q + x_i;
    end

    always_ff @(posedge clock) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator recovering 20-bit samples from a DSM bitstream.
// Define DSM_DEC_SETTLE_EN to suppress the first ORDER (transient) samples.
module dsm_cic_decimator
    import dsm_pkg::*;
#(
    parameter int DECIM = 64,
    parameter int ORDER = CIC_ORDER,
    parameter int ACC_W = 3 * log2_decim(DECIM) + 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                settled
);

    localparam int LOG2_D   = log2_decim(DECIM);
    localparam int SHIFT    = 3 * LOG2_D - 15;
    localparam int SETTLE_W = $clog2(ORDER + 1);

    if (ORDER != CIC_ORDER) begin : g_order_chk
        $error("dsm_cic_decimator: ORDER must be 3");
    end
    if (DECIM < 32 || DECIM > 256 || (1 << LOG2_D) != DECIM) begin : g_decim_chk
        $error("dsm_cic_decimator: DECIM must be a power of two in 32..256");
    end

    logic [LOG2_D-1:0]   phase_q, phase_d;
    logic                strobe;
    logic [ACC_W-1:0]    x_ext;
    logic [ACC_W-1:0]    integ_in [ORDER];
    logic [ACC_W-1:0]    integ_q  [ORDER];
    logic [ACC_W-1:0]    dly1_q, dly2_q, dly3_q;
    logic [ACC_W-1:0]    c0, c1, c2, c3;
    logic signed [ACC_W-1:0] scaled_s;
    logic [SAMPLE_W-1:0] sample_d;
    logic [SAMPLE_W-1:0] sample_out_q;
    logic                sample_valid_q;
    logic                settled_q;
    logic [SETTLE_W-1:0] settle_cnt_q;

    assign x_ext = ACC_W'(bit_to_pm1(bit_in));

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        if (k == 0) begin : g_first
            assign integ_in[k] = x_ext;
        end else begin : g_rest
            assign integ_in[k] = integ_q[k-1];
        end
        cic_integrator #(.W(ACC_W)) u_integ (
            .clock (clock),
            .reset (reset),
            .en_i  (bit_valid),
            .x_i   (integ_in[k]),
            .acc_o (integ_q[k])
        );
    end

    always_comb begin
        phase_d = phase_q;
        if (bit_valid) phase_d = phase_q + 1'b1;
    end

    assign strobe = bit_valid && (phase_q == LOG2_D'(DECIM - 1));

    // Comb input is the last integrator's value including this cycle's accept.
    assign c0 = integ_q[ORDER-1] + integ_q[ORDER-2];
    assign c1 = c0 - dly1_q;
    assign c2 = c1 - dly2_q;
    assign c3 = c2 - dly3_q;

    assign scaled_s = signed'(c3) >>> SHIFT;
    assign sample_d = SAMPLE_W'(scaled_s);

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q        <= '0;
            dly1_q         <= '0;
            dly2_q         <= '0;
            dly3_q         <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            settled_q      <= 1'b0;
            settle_cnt_q   <= '0;
        end else begin
            phase_q        <= phase_d;
            sample_valid_q <= 1'b0;
            if (strobe) begin
                dly1_q <= c0;
                dly2_q <= c1;
                dly3_q <= c2;
                if (settle_cnt_q != SETTLE_W'(ORDER)) settle_cnt_q <= settle_cnt_q + 1'b1;
                else                                  settled_q    <= 1'b1;
`ifdef DSM_DEC_SETTLE_EN
                if (settle_cnt_q == SETTLE_W'(ORDER)) begin
                    sample_out_q   <= sample_d;
                    sample_valid_q <= 1'b1;
                end
`else
                sample_out_q   <= sample_d;
                sample_valid_q <= 1'b1;
`endif
            end
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign settled      = settled_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed and randomized bench for dsm_cic_decimator (DECIM=64) with a closed-form CIC model.
module tb_dsm_cic_decimator;

    logic        clock = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic [19:0] sample_out;
    logic        sample_valid;
    logic        settled;

    int total = 0;
    int bad   = 0;

    int          n_acc;
    int          k_strobe;
    bit          bits[$];
    bit          const_en;
    logic [19:0] const_exp;
    bit          trans_chk;

`ifdef DSM_DEC_SETTLE_EN
    localparam bit SUPPRESS = 1'b1;
`else
    localparam bit SUPPRESS = 1'b0;
`endif

    always #5 clock = ~clock;

    dsm_cic_decimator dut (
        .clock        (clock),
        .reset        (reset),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .settled      (settled)
    );

    // Triple-integrated value after n accepted bits: each bit x_j contributes x_j * C(n-j, 2).
    function automatic longint i3_at(int n);
        longint s = 0;
        for (int j = 1; j <= n; j++) begin
            longint t = n - j;
            s += (bits[j-1] ? 64'sd1 : -64'sd1) * ((t * (t - 1)) / 2);
        end
        return s;
    endfunction

    // k-th decimated sample: third finite difference of i3 at window ends, scaled by 2^-3.
    function automatic logic [19:0] model_sample(int k);
        longint y;
        y = i3_at(64*k) - 3*i3_at(64*(k-1)) + 3*i3_at(64*(k-2)) - i3_at(64*(k-3));
        y = y >>> 3;
        return y[19:0];
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (accepted=%0d)", tag, obs, exp, n_acc);
        end
    endtask

    task automatic step(input logic bv, input logic b);
        bit strobe;
        bit exp_valid;
        bit_valid = bv;
        bit_in    = b;
        @(posedge clock);
        #1;
        strobe = 1'b0;
        if (bv) begin
            bits.push_back(b);
            n_acc++;
            if (n_acc % 64 == 0) begin
                strobe = 1'b1;
                k_strobe++;
            end
        end
        exp_valid = strobe && (!SUPPRESS || k_strobe > 3);
        check("sample_valid", 20'(sample_valid), 20'(exp_valid));
        check("settled", 20'(settled), 20'(k_strobe >= 4));
        if (exp_valid && sample_valid) begin
            check("sample_out", sample_out, model_sample(k_strobe));
            if (const_en && k_strobe >= 4) check("steady_value", sample_out, const_exp);
            if (trans_chk && k_strobe == 1) begin
                total++;
                assert (sample_out > 20'h0_0000 && sample_out < 20'h0_8000) else begin
                    bad++;
                    $error("FAIL transient: observed=%h expected strictly between 0 and 08000", sample_out);
                end
            end
        end
    endtask

    task automatic do_reset(input logic bv);
        reset     = 1'b1;
        bit_valid = bv;
        bit_in    = 1'b1;
        @(posedge clock);
        #1;
        check("rst_sample_valid", 20'(sample_valid), 20'h0);
        check("rst_settled", 20'(settled), 20'h0);
        check("rst_sample_out", sample_out, 20'h0);
        reset     = 1'b0;
        bit_valid = 1'b0;
        n_acc     = 0;
        k_strobe  = 0;
        bits.delete();
    endtask

    initial begin
        reset     = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        const_en  = 1'b0;
        const_exp = 20'h0;
        trans_chk = 1'b0;
        n_acc     = 0;
        k_strobe  = 0;
        do_reset(1'b0);

        // all-ones, continuous
        const_en = 1'b1; const_exp = 20'h0_8000; trans_chk = !SUPPRESS;
        repeat (5*64) step(1'b1, 1'b1);
        trans_chk = 1'b0;

        // reset landing on the 64th accept drops that strobe
        do_reset(1'b0);
        repeat (63) step(1'b1, 1'b1);
        do_reset(1'b1);
        check("dropped_strobe_valid", 20'(sample_valid), 20'h0);

        // all-zeros
        const_exp = 20'hF_8000;
        repeat (5*64) step(1'b1, 1'b0);

        do_reset(1'b0);
        const_exp = 20'h0_0000;
        for (int i = 0; i < 5*64; i++) step(1'b1, (i % 2) == 0);

        do_reset(1'b0);
        const_exp = 20'h0_4000;
        for (int i = 0; i < 5*64; i++) step(1'b1, (i % 4) != 3);

        // all-ones with bit_valid every other cycle
        do_reset(1'b0);
        const_exp = 20'h0_8000;
        for (int i = 0; i < 10*64; i++) step((i % 2) == 0, 1'b1);

        // reset after 100 accepted bits, then steady all-ones
        do_reset(1'b0);
        repeat (100) step(1'b1, 1'b1);
        do_reset(1'b0);
        repeat (5*64) step(1'b1, 1'b1);

        // randomized bits and gaps, checked only against the model
        do_reset(1'b0);
        const_en = 1'b0;
        for (int i = 0; i < 900; i++) step($urandom_range(0, 3) != 0, 1'($urandom));
        repeat (40) step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 1) != 0, 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
